// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a scanned seven-segment bus and converts each captured frame to magnitude plus sign
module seg7_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int OUT_W          = 14,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        value,
    output logic                    neg,
    output logic                    err,
    output logic [4*NUM_DIGITS-1:0] digits
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0] C_MINUS = 4'hA;
    localparam logic [3:0] C_BAD   = 4'hE;
    localparam logic [3:0] C_BLANK = 4'hF;

    typedef enum logic [1:0] {COLLECT, CONVERT, HOLD} state_t;

    state_t                  state, state_nx;
    logic [NUM_DIGITS-1:0]   prev_an;
    logic [7:0]              prev_seg;
    logic [CW-1:0]           cnt, run;
    logic                    armed, armed_eff, an_chg, same, an_ok, hit, cap;
    logic [KW-1:0]           slot, kidx;
    logic [7:0]              seg_m;
    logic [3:0]              code_in, cur;
    logic [3:0]              codes [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   seen, seen_nx;
    logic [OUT_W-1:0]        acc, acc_nx;
    logic                    sm, sm_nx, sd, sd_nx, bad, bad_nx, cdone, fin_err;

    // Normalise to active-low with the decimal point forced off so dp never affects decode
    assign seg_m = (SEG_ACTIVE_LOW ? seg : ~seg) | 8'h80;

    // Map a normalised pattern to a digit, minus, blank or invalid code
    always_comb begin
        case (seg_m)
            8'hC0:   code_in = 4'h0;
            8'hF9:   code_in = 4'h1;
            8'hA4:   code_in = 4'h2;
            8'hB0:   code_in = 4'h3;
            8'h99:   code_in = 4'h4;
            8'h92:   code_in = 4'h5;
            8'h82:   code_in = 4'h6;
            8'hF8:   code_in = 4'h7;
            8'h80:   code_in = 4'h8;
            8'h90:   code_in = 4'h9;
            8'hBF:   code_in = C_MINUS;
            8'hFF:   code_in = C_BLANK;
            default: code_in = C_BAD;
        endcase
    end

    // Locate the single active-low anode; only meaningful when an_ok
    always_comb begin
        slot = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!an[i]) slot = KW'(i);
    end

    assign an_ok     = $onehot(~an);
    assign an_chg    = an != prev_an;
    assign same      = !an_chg && seg == prev_seg;
    assign run       = !an_ok ? '0 : !same ? CW'(1) : (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;
    assign armed_eff = armed | an_chg;
    assign hit       = an_ok && armed_eff && run == CW'(STABLE_CYCLES);
    assign cap       = hit && state == COLLECT;
    assign seen_nx   = seen | (cap ? NUM_DIGITS'(1) << slot : '0);

    // Track the previous sample, the run length of identical samples and the one-shot arm per dwell
    always_ff @(posedge clk_in) begin
        if (rst) begin
            prev_an  <= '1;
            prev_seg <= '0;
            cnt      <= '0;
            armed    <= 1'b1;
        end else begin
            prev_an  <= an;
            prev_seg <= seg;
            cnt      <= run;
            armed    <= armed_eff & ~hit;
        end
    end

    // Slot codes and seen mask; only written while collecting, cleared when a result is taken
    always_ff @(posedge clk_in) begin
        if (rst) begin
            seen  <= '0;
            codes <= '{default: C_BLANK};
        end else if (state == HOLD && out_ready) begin
            seen <= '0;
        end else if (cap) begin
            codes[slot] <= code_in;
            seen        <= seen_nx;
        end
    end

    assign cur = codes[kidx];

    // One conversion step: accumulate digits and track sign/format legality
    always_comb begin
        acc_nx = acc;
        sm_nx  = sm;
        sd_nx  = sd;
        bad_nx = bad;
        if (cur <= 4'd9) begin
            acc_nx = acc * OUT_W'(10) + OUT_W'(cur);
            sd_nx  = 1'b1;
        end else if (cur == C_MINUS) begin
            bad_nx = bad | sd | sm;
            sm_nx  = 1'b1;
        end else if (cur == C_BLANK) begin
            bad_nx = bad | sd;
        end else begin
            bad_nx = 1'b1;
        end
    end

    // A lone minus without any digit is malformed too
    assign fin_err = bad | (sm & ~sd);

    // Walk slots msb to lsb during CONVERT; cdone marks the final accumulated state
    always_ff @(posedge clk_in) begin
        if (rst || state == COLLECT) begin
            acc   <= '0;
            sm    <= 1'b0;
            sd    <= 1'b0;
            bad   <= 1'b0;
            cdone <= 1'b0;
            kidx  <= KW'(NUM_DIGITS - 1);
        end else if (state == CONVERT && !cdone) begin
            acc   <= acc_nx;
            sm    <= sm_nx;
            sd    <= sd_nx;
            bad   <= bad_nx;
            cdone <= kidx == '0;
            kidx  <= kidx - 1'b1;
        end
    end

    // Result registers load on HOLD entry and stay frozen until the next frame completes
    always_ff @(posedge clk_in) begin
        if (rst) begin
            value  <= '0;
            neg    <= 1'b0;
            err    <= 1'b0;
            digits <= '1;
        end else if (state == CONVERT && cdone) begin
            value <= fin_err ? '0 : acc;
            neg   <= ~fin_err & sm;
            err   <= fin_err;
            for (int k = 0; k < NUM_DIGITS; k++)
                digits[4*k +: 4] <= codes[k];
        end
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) state <= COLLECT;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: state_nx = &seen_nx ? CONVERT : COLLECT;
            CONVERT: state_nx = cdone ? HOLD : CONVERT;
            HOLD:    state_nx = out_ready ? COLLECT : HOLD;
            default: state_nx = COLLECT;
        endcase
    end

    assign out_valid = state == HOLD;
endmodule
